sdrd_deserializer: RTL and testbench
====================================

SDRD_DESERIALIZER -- requirements
Module: sdrd_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per assembled word.
REQ-002 SHALL have parameter TIMEOUT, default 1024: idle clk cycles allowed between bits of a partial word.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port bus_stb, input, 1: one-cycle pulse marking the completion of a bus cycle.
REQ-006 SHALL have port sser_n, input, 1: serial-window select, active-low.
REQ-007 SHALL have port ba13, ba12, input, 1 each: bus address bits; the window is ba13=0, ba12=1.
REQ-008 SHALL have port br_w, input, 1: bus direction; 1 means read, 0 means write.
REQ-009 SHALL have port sdrd, input, 1: serial response bit from the upstream sequencer.
REQ-010 SHALL have port sdrd_vld, input, 1: sdrd is actively driven this cycle.
REQ-011 SHALL have port rx_data, output, WIDTH: assembled word in the holding register.
REQ-012 SHALL have port rx_valid, output, 1: holding register is full.
REQ-013 SHALL have port rx_ready, input, 1: consumer accepts rx_data.
REQ-014 SHALL have port bit_cnt, output, clog2(WIDTH): number of bits in the current partial word.
REQ-015 SHALL have ports ovr, tmo, and frm, output, 1 each: sticky overrun, timeout, and framing flags.
REQ-016 SHALL have port clr_err, input, 1: one-cycle pulse that clears ovr, tmo, and frm.

Function
REQ-017 A read hit SHALL be defined as bus_stb & ~sser_n & ~ba13 & ba12 & br_w.
REQ-018 A write hit SHALL be defined as the same condition with br_w=0.
REQ-019 On a read hit with sdrd_vld=1, the block SHALL shift sdrd into the shift register MSB-first and increment bit_cnt.
REQ-020 On a read hit with sdrd_vld=0, the block SHALL set frm, discard the partial word, and return to IDLE.
REQ-021 The FSM SHALL have two states: IDLE (bit_cnt=0) and SHIFT (partial word held); the first accepted bit moves IDLE to SHIFT.
REQ-022 When the WIDTH-th bit is accepted, the block SHALL load the completed word into rx_data with the same edge, set rx_valid, clear bit_cnt, and enter IDLE; latency from the last read hit to rx_valid is one cycle.
REQ-023 A transfer SHALL occur when rx_valid & rx_ready; with no new completion in that cycle, rx_valid SHALL clear on the next edge.
REQ-024 If a completion and a transfer occur in the same cycle, the new word SHALL load, rx_valid SHALL stay 1, and ovr SHALL not be set.
REQ-025 If a completion occurs while rx_valid=1 and no transfer happens, ovr SHALL be set, the new word SHALL be discarded, and rx_data SHALL be unchanged.
REQ-026 A write hit SHALL clear the shift register and bit_cnt and enter IDLE; it SHALL not affect rx_data or rx_valid.
REQ-027 In SHIFT, the idle counter SHALL count clk cycles with no read hit; at TIMEOUT-1 it SHALL set tmo, discard the partial word, and enter IDLE.
REQ-028 Any read hit SHALL reset the idle counter.
REQ-029 In IDLE the idle counter SHALL be held at 0.
REQ-030 If a write hit and a read hit would both apply, the write hit SHALL take precedence (they are mutually exclusive via br_w); a write hit SHALL also take precedence over a timeout in the same cycle.
REQ-031 clr_err SHALL clear the flags, but an error event in the same cycle SHALL win and the flag SHALL stay set.
REQ-032 bus_stb with the window not selected SHALL have no effect.

Reset
REQ-033 When rst_n=0, the block SHALL set: state IDLE, shift register 0, bit_cnt 0, idle counter 0, rx_data 0, rx_valid 0, ovr 0, tmo 0, frm 0.
REQ-034 Reset asserted mid-word SHALL discard the partial word and any held word.
REQ-035 Reset deassertion SHALL take effect on the next clk edge with no spurious rx_valid.

Structure
REQ-036 A shared package SHALL hold the FSM state enum (IDLE, SHIFT) and the window-decode constants (BA13=0, BA12=1).
REQ-037 WIDTH and TIMEOUT SHALL remain module parameters.
REQ-038 The block SHALL have no sub-module; the shift register, holding register, and idle counter SHALL be inline.

Verification
REQ-039 Eight read hits with sdrd=1,0,1,0,0,1,1,0 and rx_ready=0 -> rx_data=0xA6, rx_valid=1 one cycle after the 8th hit, bit_cnt=0.
REQ-040 A second 8-bit word completes while rx_valid=1 and rx_ready=0 -> ovr=1 and rx_data stays 0xA6; with rx_ready=1 on the completing cycle -> new word loaded, ovr=0.
REQ-041 Three bits are shifted, then a write hit occurs -> bit_cnt=0, state IDLE; a following 8 bits assemble correctly.
REQ-042 Two bits are shifted, then TIMEOUT=16 cycles pass with no hit -> tmo=1 on cycle 15, bit_cnt=0; clr_err -> tmo=0.
REQ-043 A read hit with sdrd_vld=0 after 5 bits -> frm=1, bit_cnt=0.
REQ-044 rst_n pulses low after 4 bits with rx_valid=1 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sdrd_deserializer_pkg.sv
// Shared types and window-decode constants for the serial response deserializer.
package sdrd_deserializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } sdrd_state_e;

   localparam logic WIN_BA13 = 1'b0;
   localparam logic WIN_BA12 = 1'b1;

   // Bus cycle lands in the serial window, independent of direction.
   function automatic logic win_hit(input logic stb, input logic sser_n,
                                    input logic ba13, input logic ba12);
      return stb & ~sser_n & (ba13 == WIN_BA13) & (ba12 == WIN_BA12);
   endfunction

endpackage

// File: rtl/sdrd_deserializer.sv
// Assembles sdrd bits sampled on serial-window read cycles into WIDTH-bit words,
// with a one-deep holding register and sticky overrun/timeout/framing flags.
module sdrd_deserializer
   import sdrd_deserializer_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bus_stb,
   input  logic             sser_n,
   input  logic             ba13,
   input  logic             ba12,
   input  logic             br_w,
   input  logic             sdrd,
   input  logic             sdrd_vld,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [$clog2(WIDTH)-1:0] bit_cnt,
   output logic             ovr,
   output logic             tmo,
   output logic             frm,
   input  logic             clr_err,
   output sdrd_state_e      dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam int IW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

   sdrd_state_e      state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idle_q, idle_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d, tmo_q, tmo_d, frm_q, frm_d;

   logic             win, read_hit, write_hit, xfer;
   logic [WIDTH-1:0] sh_shift;
   logic [IW-1:0]    idle_inc;

   assign win       = win_hit(bus_stb, sser_n, ba13, ba12);
   assign read_hit  = win & br_w;
   assign write_hit = win & ~br_w;
   assign xfer      = valid_q & rx_ready;
   assign sh_shift  = {sh_q[WIDTH-2:0], sdrd};
   assign idle_inc  = idle_q + 1'b1;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      data_d  = data_q;
      valid_d = valid_q & ~xfer;
      // Flag clear is applied first so a same-cycle error re-sets it below.
      ovr_d   = ovr_q & ~clr_err;
      tmo_d   = tmo_q & ~clr_err;
      frm_d   = frm_q & ~clr_err;

      if (write_hit) begin
         state_d = ST_IDLE;
         sh_d    = '0;
         cnt_d   = '0;
         idle_d  = '0;
      end else if (read_hit) begin
         idle_d = '0;
         if (!sdrd_vld) begin
            frm_d   = 1'b1;
            state_d = ST_IDLE;
            sh_d    = '0;
            cnt_d   = '0;
         end else if (cnt_q == LAST_BIT) begin
            state_d = ST_IDLE;
            sh_d    = '0;
            cnt_d   = '0;
            if (!valid_q || xfer) begin
               data_d  = sh_shift;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end else begin
            state_d = ST_SHIFT;
            sh_d    = sh_shift;
            cnt_d   = cnt_q + 1'b1;
         end
      end else if (state_q == ST_SHIFT) begin
         if (idle_inc == IDLE_MAX) begin
            tmo_d   = 1'b1;
            state_d = ST_IDLE;
            sh_d    = '0;
            cnt_d   = '0;
            idle_d  = '0;
         end else begin
            idle_d = idle_inc;
         end
      end else begin
         idle_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         idle_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         tmo_q   <= 1'b0;
         frm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         tmo_q   <= tmo_d;
         frm_q   <= frm_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign bit_cnt   = cnt_q;
   assign ovr       = ovr_q;
   assign tmo       = tmo_q;
   assign frm       = frm_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Directed bench for sdrd_deserializer: words delivered on rx_valid & rx_ready are
// checked against an expected queue; flags and counters are checked inline.
module tb_sdrd_deserializer;
   import sdrd_deserializer_pkg::*;

   localparam int W  = 8;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         bus_stb = 1'b0, sser_n = 1'b1, ba13 = 1'b0, ba12 = 1'b0, br_w = 1'b0;
   logic         sdrd = 1'b0, sdrd_vld = 1'b0, rx_ready = 1'b0, clr_err = 1'b0;
   logic [W-1:0] rx_data;
   logic         rx_valid, ovr, tmo, frm;
   logic [2:0]   bit_cnt;
   sdrd_state_e  dbg_state;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] exp_q[$];

   sdrd_deserializer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .bus_stb(bus_stb), .sser_n(sser_n),
      .ba13(ba13), .ba12(ba12), .br_w(br_w), .sdrd(sdrd), .sdrd_vld(sdrd_vld),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .bit_cnt(bit_cnt), .ovr(ovr), .tmo(tmo), .frm(frm), .clr_err(clr_err),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // drivers
   task automatic hit(input logic b, input logic vld, input logic rdy, input logic clr);
      @(negedge clk);
      bus_stb = 1'b1; sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1;
      sdrd = b; sdrd_vld = vld; rx_ready = rdy; clr_err = clr;
      @(negedge clk);
      bus_stb = 1'b0; sdrd_vld = 1'b0; clr_err = 1'b0;
   endtask

   task automatic write_hit();
      @(negedge clk);
      bus_stb = 1'b1; sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b0;
      @(negedge clk);
      bus_stb = 1'b0; br_w = 1'b1;
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic rdy_last);
      for (int i = W - 1; i >= 0; i--)
         hit(w[i], 1'b1, (i == 0) ? rdy_last : rx_ready, 1'b0);
   endtask

   task automatic pulse_clr();
      @(negedge clk); clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
   endtask

   task automatic drain();
      @(negedge clk); rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
   endtask

   // scoreboard monitor: sample settled inputs just after the driving edge
   always @(negedge clk) begin
      #1;
      if (rst_n && rx_valid && rx_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got 0x%0h, expected no word", rx_data);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (rx_data !== e) begin
               n_fail++;
               $display("FAIL sb_word: got 0x%0h, expected 0x%0h", rx_data, e);
            end
         end
      end
   end

   logic [W-1:0] a6;

   initial begin
      a6 = 8'hA6;
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_cnt", bit_cnt, 0);
      chk("rst_flags", {ovr, tmo, frm}, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_valid", rx_valid, 0);

      // first word 1,0,1,0,0,1,1,0 held with rx_ready low
      for (int i = W - 1; i >= 1; i--) hit(a6[i], 1'b1, 1'b0, 1'b0);
      chk("a6_cnt7", bit_cnt, 7);
      chk("a6_state_shift", dbg_state, ST_SHIFT);
      chk("a6_not_yet", rx_valid, 0);
      exp_q.push_back(8'hA6);
      hit(a6[0], 1'b1, 1'b0, 1'b0);
      chk("a6_valid", rx_valid, 1);
      chk("a6_data", rx_data, 8'hA6);
      chk("a6_cnt0", bit_cnt, 0);
      chk("a6_state_idle", dbg_state, ST_IDLE);

      // completion while full and not accepted -> overrun, word dropped
      send_word(8'h3C, 1'b0);
      chk("ovr_set", ovr, 1);
      chk("ovr_data_kept", rx_data, 8'hA6);
      chk("ovr_valid_kept", rx_valid, 1);
      pulse_clr();
      chk("ovr_cleared", ovr, 0);

      // completion coinciding with transfer -> new word, no overrun
      exp_q.push_back(8'h5F);
      send_word(8'h5F, 1'b1);
      chk("xfer_data", rx_data, 8'h5F);
      chk("xfer_valid", rx_valid, 1);
      chk("xfer_no_ovr", ovr, 0);
      @(negedge clk); rx_ready = 1'b0;
      chk("xfer_valid_clr", rx_valid, 0);

      // write hit aborts a partial word
      hit(1'b1, 1'b1, 1'b0, 1'b0);
      hit(1'b1, 1'b1, 1'b0, 1'b0);
      hit(1'b0, 1'b1, 1'b0, 1'b0);
      chk("wr_cnt3", bit_cnt, 3);
      write_hit();
      chk("wr_cnt0", bit_cnt, 0);
      chk("wr_state", dbg_state, ST_IDLE);
      chk("wr_valid_untouched", rx_valid, 0);
      exp_q.push_back(8'hC3);
      send_word(8'hC3, 1'b0);
      chk("wr_next_data", rx_data, 8'hC3);
      drain();

      // timeout after two bits
      hit(1'b1, 1'b1, 1'b0, 1'b0);
      hit(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (TO - 2) @(negedge clk);
      chk("tmo_early", tmo, 0);
      chk("tmo_early_cnt", bit_cnt, 2);
      @(negedge clk);
      chk("tmo_set", tmo, 1);
      chk("tmo_cnt", bit_cnt, 0);
      chk("tmo_state", dbg_state, ST_IDLE);
      pulse_clr();
      chk("tmo_cleared", tmo, 0);

      // framing: undriven sdrd after five bits
      for (int i = 0; i < 5; i++) hit(i[0], 1'b1, 1'b0, 1'b0);
      chk("frm_cnt5", bit_cnt, 5);
      hit(1'b0, 1'b0, 1'b0, 1'b0);
      chk("frm_set", frm, 1);
      chk("frm_cnt0", bit_cnt, 0);
      // clear and a new framing error in the same cycle: error wins
      hit(1'b0, 1'b0, 1'b0, 1'b1);
      chk("frm_clr_race", frm, 1);
      pulse_clr();
      chk("frm_cleared", frm, 0);

      // bus strobe outside the window is ignored
      hit(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      bus_stb = 1'b1; sser_n = 1'b1; sdrd_vld = 1'b1;
      @(negedge clk);
      bus_stb = 1'b1; sser_n = 1'b0; ba12 = 1'b0;
      @(negedge clk);
      bus_stb = 1'b0; ba12 = 1'b1; sdrd_vld = 1'b0;
      chk("nowin_cnt", bit_cnt, 1);
      write_hit();

      // asynchronous reset with a held word and a partial word
      send_word(8'h81, 1'b0);
      for (int i = 0; i < 4; i++) hit(1'b1, 1'b1, 1'b0, 1'b0);
      chk("prerst_valid", rx_valid, 1);
      chk("prerst_cnt", bit_cnt, 4);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_outputs", {rx_data, rx_valid, bit_cnt, ovr, tmo, frm}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_valid", rx_valid, 0);

      exp_q.push_back(8'h96);
      send_word(8'h96, 1'b0);
      drain();
      @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
